channel_buffer_ctrl: RTL and testbench

Single-clock controller that sequences the Channel_Buffer_BRAM mixed-width buffer (2048×16 write port, 128×256 read port) as a two-page ping-pong store. It packs an incoming 16-bit sample stream into 256-bit words (16 samples per word, 64 words per page), and drains each completed page to a downstream consumer over a valid/ready interface. It sits between the per-channel sample front end and the event packer, and it hides the BRAM read latency behind a credit-controlled skid FIFO.

---
 rtl/channel_buffer_ctrl_if.sv | 16 +
 rtl/channel_buffer_ctrl.sv | 210 +++++++++++++++++++++
 tb/tb_channel_buffer_ctrl.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/channel_buffer_ctrl_if.sv
// Sample-in / packed-word-out valid-ready streams of channel_buffer_ctrl.
// master = producer/consumer side, slave = the buffer controller.
interface channel_buffer_ctrl_if;
    logic         in_valid;
    logic [15:0]  in_data;
    logic         in_ready;
    logic         out_valid;
    logic [255:0] out_data;
    logic         out_last;
    logic         out_ready;

    modport master (output in_valid, in_data, out_ready,
                    input  in_ready, out_valid, out_data, out_last);
    modport slave  (input  in_valid, in_data, out_ready,
                    output in_ready, out_valid, out_data, out_last);
endinterface

// File: rtl/channel_buffer_ctrl.sv
// Ping-pong page sequencer for the 2048x16 / 128x256 channel buffer BRAM.
// Define CHANNEL_BUFFER_CTRL_DROP_EN to drop (and count) samples instead of back-pressuring.
module channel_buffer_ctrl #(
    parameter int RD_LATENCY = 2
) (
    input  logic                 clk,
    input  logic                 rst_n,
    channel_buffer_ctrl_if.slave io,
    output logic [15:0]          bram_data,
    output logic [10:0]          bram_wraddress,
    output logic                 bram_wren,
    output logic [6:0]           bram_rdaddress,
    output logic                 bram_rden,
    input  logic [255:0]         bram_q,
    output logic [1:0]           page_full,
    output logic [15:0]          drop_cnt
);
    localparam int FIFO_DEPTH = RD_LATENCY + 2;
    localparam int CW = $clog2(FIFO_DEPTH + 1);
    localparam int IW = $clog2(FIFO_DEPTH);

    typedef enum logic [1:0] {RD_IDLE, RD_ISSUE, RD_DRAIN} rd_state_e;

    logic [9:0]   wr_ptr_q, wr_ptr_d;
    logic         wr_page_q, wr_page_d;
    logic [1:0]   page_full_q, page_full_d;
    logic         set_pend_q, set_pend_d;
    logic         set_page_q, set_page_d;
    logic [15:0]  bram_data_q, bram_data_d;
    logic [10:0]  bram_wraddress_q, bram_wraddress_d;
    logic         bram_wren_q, bram_wren_d;
    logic         in_full, in_acc;

    rd_state_e    rd_state_q, rd_state_d;
    logic         rd_page_q, rd_page_d;
    logic [5:0]   rd_word_q, rd_word_d;
    logic [RD_LATENCY-1:0] tag_vld_q, tag_vld_d, tag_last_q, tag_last_d;
    logic [CW-1:0] inflight_q, inflight_d;
    logic [FIFO_DEPTH-1:0][255:0] fifo_data_q, fifo_data_d;
    logic [FIFO_DEPTH-1:0]        fifo_last_q, fifo_last_d;
    logic [IW-1:0] fifo_wp_q, fifo_wp_d, fifo_rp_q, fifo_rp_d;
    logic [CW-1:0] fifo_cnt_q, fifo_cnt_d;

    logic         issue, clr, credit_ok, cap, cap_last, fifo_empty;
    logic         head_valid, head_last, pop, fifo_pop, push;
    logic [255:0] head_data;

    // Write side: register the accepted sample onto the BRAM port; the page-full
    // flag is raised one cycle later, together with the final write of the page.
    always_comb begin
        in_full          = page_full_q[wr_page_q];
        in_acc           = io.in_valid && !in_full;
        wr_ptr_d         = wr_ptr_q;
        wr_page_d        = wr_page_q;
        bram_wren_d      = in_acc;
        bram_data_d      = bram_data_q;
        bram_wraddress_d = bram_wraddress_q;
        set_pend_d       = 1'b0;
        set_page_d       = set_page_q;
        if (in_acc) begin
            bram_data_d      = io.in_data;
            bram_wraddress_d = {wr_page_q, wr_ptr_q};
            wr_ptr_d         = wr_ptr_q + 10'd1;
            if (wr_ptr_q == 10'd1023) begin
                wr_page_d  = ~wr_page_q;
                set_pend_d = 1'b1;
                set_page_d = wr_page_q;
            end
        end
    end

`ifdef CHANNEL_BUFFER_CTRL_DROP_EN
    logic [15:0] drop_cnt_q, drop_cnt_d;

    assign io.in_ready = 1'b1;
    assign drop_cnt    = drop_cnt_q;

    always_comb begin
        drop_cnt_d = drop_cnt_q;
        if (io.in_valid && in_full && drop_cnt_q != 16'hFFFF)
            drop_cnt_d = drop_cnt_q + 16'd1;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) drop_cnt_q <= '0;
        else        drop_cnt_q <= drop_cnt_d;
    end
`else
    assign io.in_ready = !in_full;
    assign drop_cnt    = '0;
`endif

    // Read side. Credits count every word from issue until the consumer takes it,
    // so the skid FIFO can never overflow however long out_ready stays low.
    always_comb begin
        cap        = tag_vld_q[RD_LATENCY-1];
        cap_last   = tag_last_q[RD_LATENCY-1];
        fifo_empty = (fifo_cnt_q == '0);
        // An empty FIFO forwards the word arriving from the BRAM this cycle.
        head_valid = !fifo_empty || cap;
        head_data  = fifo_empty ? (cap ? bram_q : '0) : fifo_data_q[fifo_rp_q];
        head_last  = fifo_empty ? cap_last : fifo_last_q[fifo_rp_q];
        pop        = head_valid && io.out_ready;
        fifo_pop   = pop && !fifo_empty;
        push       = cap && !(fifo_empty && pop);
        credit_ok  = inflight_q < CW'(FIFO_DEPTH);

        rd_state_d = rd_state_q;
        rd_page_d  = rd_page_q;
        rd_word_d  = rd_word_q;
        issue      = 1'b0;
        clr        = 1'b0;
        case (rd_state_q)
            RD_IDLE: if (page_full_q[rd_page_q]) begin
                rd_state_d = RD_ISSUE;
                issue      = credit_ok;
            end
            RD_ISSUE: issue = credit_ok;
            RD_DRAIN: if (pop && head_last) begin
                clr        = 1'b1;
                rd_page_d  = ~rd_page_q;
                rd_state_d = RD_IDLE;
            end
            default: rd_state_d = RD_IDLE;
        endcase
        if (issue) begin
            rd_word_d = rd_word_q + 6'd1;
            if (rd_word_q == 6'd63) rd_state_d = RD_DRAIN;
        end

        page_full_d = page_full_q;
        if (set_pend_q) page_full_d[set_page_q] = 1'b1;
        if (clr)        page_full_d[rd_page_q]  = 1'b0;

        tag_vld_d[0]  = issue;
        tag_last_d[0] = issue && (rd_word_q == 6'd63);
        for (int i = 1; i < RD_LATENCY; i++) begin
            tag_vld_d[i]  = tag_vld_q[i-1];
            tag_last_d[i] = tag_last_q[i-1];
        end

        fifo_data_d = fifo_data_q;
        fifo_last_d = fifo_last_q;
        fifo_wp_d   = fifo_wp_q;
        fifo_rp_d   = fifo_rp_q;
        if (push) begin
            fifo_data_d[fifo_wp_q] = bram_q;
            fifo_last_d[fifo_wp_q] = cap_last;
            fifo_wp_d = (fifo_wp_q == IW'(FIFO_DEPTH - 1)) ? '0 : fifo_wp_q + IW'(1);
        end
        if (fifo_pop)
            fifo_rp_d = (fifo_rp_q == IW'(FIFO_DEPTH - 1)) ? '0 : fifo_rp_q + IW'(1);
        fifo_cnt_d = fifo_cnt_q + CW'(push) - CW'(fifo_pop);
        inflight_d = inflight_q + CW'(issue) - CW'(pop);
    end

    assign io.out_valid    = head_valid;
    assign io.out_data     = head_data;
    assign io.out_last     = head_last;
    assign bram_rden       = issue;
    assign bram_rdaddress  = {rd_page_q, rd_word_q};
    assign bram_data       = bram_data_q;
    assign bram_wraddress  = bram_wraddress_q;
    assign bram_wren       = bram_wren_q;
    assign page_full       = page_full_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q         <= '0;
            wr_page_q        <= 1'b0;
            page_full_q      <= '0;
            set_pend_q       <= 1'b0;
            set_page_q       <= 1'b0;
            bram_data_q      <= '0;
            bram_wraddress_q <= '0;
            bram_wren_q      <= 1'b0;
            rd_state_q       <= RD_IDLE;
            rd_page_q        <= 1'b0;
            rd_word_q        <= '0;
            tag_vld_q        <= '0;
            tag_last_q       <= '0;
            inflight_q       <= '0;
            fifo_data_q      <= '0;
            fifo_last_q      <= '0;
            fifo_wp_q        <= '0;
            fifo_rp_q        <= '0;
            fifo_cnt_q       <= '0;
        end else begin
            wr_ptr_q         <= wr_ptr_d;
            wr_page_q        <= wr_page_d;
            page_full_q      <= page_full_d;
            set_pend_q       <= set_pend_d;
            set_page_q       <= set_page_d;
            bram_data_q      <= bram_data_d;
            bram_wraddress_q <= bram_wraddress_d;
            bram_wren_q      <= bram_wren_d;
            rd_state_q       <= rd_state_d;
            rd_page_q        <= rd_page_d;
            rd_word_q        <= rd_word_d;
            tag_vld_q        <= tag_vld_d;
            tag_last_q       <= tag_last_d;
            inflight_q       <= inflight_d;
            fifo_data_q      <= fifo_data_d;
            fifo_last_q      <= fifo_last_d;
            fifo_wp_q        <= fifo_wp_d;
            fifo_rp_q        <= fifo_rp_d;
            fifo_cnt_q       <= fifo_cnt_d;
        end
    end
endmodule

// File: tb/tb_channel_buffer_ctrl.sv
// Directed bench for channel_buffer_ctrl: BRAM model, page-level reference model
// checked every cycle, plus hand-computed pins for latency, word layout and counts.
module tb_channel_buffer_ctrl;
    localparam int RD_LATENCY = 2;
    localparam int FIFO_DEPTH = RD_LATENCY + 2;

    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    channel_buffer_ctrl_if bus();
    logic [15:0]  bram_data;
    logic [10:0]  bram_wraddress;
    logic         bram_wren;
    logic [6:0]   bram_rdaddress;
    logic         bram_rden;
    logic [255:0] bram_q;
    logic [1:0]   page_full;
    logic [15:0]  drop_cnt;

    channel_buffer_ctrl #(.RD_LATENCY(RD_LATENCY)) dut (
        .clk(clk), .rst_n(rst_n), .io(bus),
        .bram_data(bram_data), .bram_wraddress(bram_wraddress), .bram_wren(bram_wren),
        .bram_rdaddress(bram_rdaddress), .bram_rden(bram_rden), .bram_q(bram_q),
        .page_full(page_full), .drop_cnt(drop_cnt)
    );

    // Mixed-width BRAM: 16-bit writes, 256-bit reads with RD_LATENCY cycles of delay.
    logic [15:0]  mem [2048];
    logic [255:0] rpipe [RD_LATENCY];

    function automatic logic [255:0] rd_word(input logic [6:0] a);
        logic [255:0] w;
        w = '0;
        for (int l = 0; l < 16; l++) w[16*l +: 16] = mem[{a, 4'(l)}];
        return w;
    endfunction

    always @(posedge clk) begin
        if (bram_wren) mem[bram_wraddress] <= bram_data;
        rpipe[0] <= bram_rden ? rd_word(bram_rdaddress) : '0;
        for (int i = 1; i < RD_LATENCY; i++) rpipe[i] <= rpipe[i-1];
    end
    assign bram_q = rpipe[RD_LATENCY-1];

    int vectors = 0;
    int miscompares = 0;
    bit abort = 0;

    task automatic chk(input string name, input logic [256:0] act, input logic [256:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Reference model: pages of 1024 accepted samples become 64 expected words.
    logic [15:0]  m_fill [$];
    logic [256:0] exp_q [$];
    bit [1:0]     m_full;
    int           m_pset [2];
    int           m_pclr [2];
    bit           m_wr_page, m_rd_page;
    int           m_wr_cnt, m_drop;
    bit           ew_vld;
    logic [10:0]  ew_addr;
    logic [15:0]  ew_data;
    bit           prev_stall;
    logic [256:0] prev_out;
    int           words_out = 0;
    int           rden_cnt = 0;

    always @(negedge clk) begin
        logic [256:0] e;
        if (!rst_n) begin
            m_fill.delete(); exp_q.delete();
            m_full = '0; m_wr_page = 0; m_rd_page = 0; m_wr_cnt = 0; m_drop = 0;
            for (int p = 0; p < 2; p++) begin m_pset[p] = 0; m_pclr[p] = 0; end
            ew_vld = 0; prev_stall = 0;
        end else begin
            for (int p = 0; p < 2; p++) begin
                if (m_pset[p] > 0) begin m_pset[p]--; if (m_pset[p] == 0) m_full[p] = 1; end
                if (m_pclr[p] > 0) begin m_pclr[p]--; if (m_pclr[p] == 0) m_full[p] = 0; end
            end
            if (bram_rden) rden_cnt++;
            chk("page_full", 257'(page_full), 257'({m_full[1], m_full[0]}));
`ifdef CHANNEL_BUFFER_CTRL_DROP_EN
            chk("in_ready", 257'(bus.in_ready), 257'(1'b1));
            chk("drop_cnt", 257'(drop_cnt), 257'(m_drop));
`else
            chk("in_ready", 257'(bus.in_ready), 257'(!m_full[m_wr_page]));
            chk("drop_cnt", 257'(drop_cnt), 257'(0));
`endif
            chk("bram_wren", 257'(bram_wren), 257'(ew_vld));
            if (ew_vld) begin
                chk("bram_wraddress", 257'(bram_wraddress), 257'(ew_addr));
                chk("bram_data", 257'(bram_data), 257'(ew_data));
            end
            if (prev_stall) begin
                chk("stall_valid", 257'(bus.out_valid), 257'(1'b1));
                chk("stall_hold", {bus.out_last, bus.out_data}, prev_out);
            end
            if (bus.out_valid) begin
                if (exp_q.size() == 0) chk("spurious_word", 257'(bus.out_valid), 257'(0));
                else begin
                    chk("out_word", {bus.out_last, bus.out_data}, exp_q[0]);
                    if (bus.out_ready) begin
                        if (exp_q[0][256]) begin m_pclr[m_rd_page] = 1; m_rd_page = !m_rd_page; end
                        void'(exp_q.pop_front());
                        words_out++;
                    end
                end
            end
            prev_stall = bus.out_valid && !bus.out_ready;
            prev_out   = {bus.out_last, bus.out_data};
            ew_vld = 0;
            if (bus.in_valid) begin
                if (!m_full[m_wr_page]) begin
                    ew_vld  = 1;
                    ew_addr = {m_wr_page, 10'(m_wr_cnt)};
                    ew_data = bus.in_data;
                    m_fill.push_back(bus.in_data);
                    m_wr_cnt++;
                    if (m_wr_cnt == 1024) begin
                        for (int w = 0; w < 64; w++) begin
                            e = '0;
                            for (int l = 0; l < 16; l++) e[16*l +: 16] = m_fill[16*w + l];
                            e[256] = (w == 63);
                            exp_q.push_back(e);
                        end
                        m_fill.delete();
                        m_pset[m_wr_page] = 2;
                        m_wr_page = !m_wr_page;
                        m_wr_cnt = 0;
                    end
                end else if (m_drop < 16'hFFFF) m_drop++;
            end
        end
    end

    task automatic send(input int v);
        int t;
        bit acc;
        t = 0; acc = 0;
        if (abort) return;
        bus.in_valid = 1'b1;
        bus.in_data  = 16'(v);
        while (!acc && t < 5000) begin
            @(negedge clk); acc = bus.in_ready;
            @(posedge clk); #1; t++;
        end
        bus.in_valid = 1'b0;
        if (!acc) begin
            chk("send_timeout", 257'(acc), 257'(1'b1));
            abort = 1;
        end
    endtask

    task automatic wait_drain();
        int t;
        t = 0;
        while ((exp_q.size() != 0 || bus.out_valid) && t < 3000) begin @(negedge clk); t++; end
        chk("drain_left", 257'(exp_q.size()), 257'(0));
        @(posedge clk); #1;
    endtask

    task automatic chk_reset();
        chk("rst_in_ready", 257'(bus.in_ready), 257'(1'b1));
        chk("rst_out_valid", 257'(bus.out_valid), 257'(0));
        chk("rst_out_last", 257'(bus.out_last), 257'(0));
        chk("rst_out_data", 257'(bus.out_data), 257'(0));
        chk("rst_bram_wren", 257'(bram_wren), 257'(0));
        chk("rst_bram_rden", 257'(bram_rden), 257'(0));
        chk("rst_bram_data", 257'(bram_data), 257'(0));
        chk("rst_bram_wraddress", 257'(bram_wraddress), 257'(0));
        chk("rst_bram_rdaddress", 257'(bram_rdaddress), 257'(0));
        chk("rst_page_full", 257'(page_full), 257'(0));
        chk("rst_drop_cnt", 257'(drop_cnt), 257'(0));
    endtask

    task automatic do_reset();
        @(posedge clk); #1 rst_n = 1'b0;
        @(negedge clk); chk_reset();
        @(posedge clk); #1 rst_n = 1'b1;
    endtask

    initial begin
        int lat, n, w0;
        logic [255:0] word0;
        word0 = 256'h000f000e000d000c000b000a0009000800070006000500040003000200010000;
        bus.in_valid = 1'b0; bus.in_data = '0; bus.out_ready = 1'b0;
        #1 rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk); chk_reset();
        @(posedge clk); #1 rst_n = 1'b1;

        // One page straight through with the consumer always ready.
        bus.out_ready = 1'b1;
        w0 = words_out;
        for (int v = 0; v < 1024; v++) send(v);
        lat = 0;
        do begin @(negedge clk); lat++; end while (!bus.out_valid && lat < 50);
        chk("first_word_latency", 257'(lat), 257'(RD_LATENCY + 2));
        chk("word0_data", 257'(bus.out_data), 257'(word0));
        chk("word0_last", 257'(bus.out_last), 257'(0));
        n = 0;
        do begin @(negedge clk); n++; end while (!(bus.out_valid && bus.out_last) && n < 200);
        chk("page_burst_cycles", 257'(n), 257'(63));
        wait_drain();
        chk("page1_words", 257'(words_out - w0), 257'(64));
        chk("page1_full_after", 257'(page_full), 257'(0));

        // Both pages filled against a stalled consumer.
        do_reset();
        bus.out_ready = 1'b0;
        rden_cnt = 0;
        w0 = words_out;
        for (int v = 0; v < 2048; v++) send(v);
        repeat (20) @(posedge clk);
        #1;
        chk("both_full", 257'(page_full), 257'(2'b11));
`ifndef CHANNEL_BUFFER_CTRL_DROP_EN
        chk("in_ready_blocked", 257'(bus.in_ready), 257'(0));
`endif
        chk("reads_while_stalled", 257'(rden_cnt), 257'(FIFO_DEPTH));
        bus.out_ready = 1'b1;
        wait_drain();
        chk("two_page_words", 257'(words_out - w0), 257'(128));

        // Consumer ready on alternate cycles.
        bus.out_ready = 1'b0;
        w0 = words_out;
        for (int v = 0; v < 1024; v++) send(16'h4000 + v);
        n = 0;
        do begin
            @(posedge clk); #1 bus.out_ready = !bus.out_ready; n++;
        end while ((exp_q.size() != 0 || bus.out_valid) && n < 400);
        chk("toggle_words", 257'(words_out - w0), 257'(64));
        chk("toggle_left", 257'(exp_q.size()), 257'(0));

`ifdef CHANNEL_BUFFER_CTRL_DROP_EN
        // Overflow discards: only the first 2048 samples are kept.
        do_reset();
        bus.out_ready = 1'b0;
        w0 = words_out;
        for (int v = 0; v < 2053; v++) send(v);
        repeat (3) @(posedge clk);
        #1;
        chk("drop_cnt_final", 257'(drop_cnt), 257'(5));
        chk("drop_full", 257'(page_full), 257'(2'b11));
        bus.out_ready = 1'b1;
        wait_drain();
        chk("drop_words", 257'(words_out - w0), 257'(128));
`endif

        // Reset in the middle of a page while reads are outstanding.
        do_reset();
        bus.out_ready = 1'b0;
        for (int v = 0; v < 1524; v++) send(v);
        repeat (3) @(posedge clk);
        #1 rst_n = 1'b0;
        @(negedge clk); chk_reset();
        @(posedge clk); #1 rst_n = 1'b1;
        bus.out_ready = 1'b1;
        w0 = words_out;
        send(16'h8000);
        chk("post_reset_wren", 257'(bram_wren), 257'(1'b1));
        chk("post_reset_addr0", 257'(bram_wraddress), 257'(0));
        for (int v = 1; v < 1024; v++) send(16'h8000 + v);
        wait_drain();
        chk("post_reset_words", 257'(words_out - w0), 257'(64));
        chk("post_reset_full", 257'(page_full), 257'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule
